// File: rtl/prbs7_xnor_checker.sv
// Serial checker for an XNOR-feedback PRBS stream (x^WIDTH + x^TAP + 1).
// Self-seeds from the stream, qualifies lock, then free-runs and counts bit errors.
module prbs7_xnor_checker #(
  parameter int WIDTH    = 7,
  parameter int TAP      = 6,
  parameter int LOCK_N   = 16,
  parameter int UNLOCK_N = 4,
  parameter int CNTW     = 16
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            DIN,
  input  logic            VALID,
  input  logic            CLR,
  output logic            LOCK,
  output logic            ERR,
  output logic [CNTW-1:0] ERRCNT
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_N + 1);
  localparam int UW = $clog2(UNLOCK_N + 1);

  localparam logic [1:0] SEED   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [SW-1:0]    seed_cnt;
  logic [SW-1:0]    seed_nxt;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_nxt;
  logic [UW-1:0]    miss_cnt;
  logic [UW-1:0]    miss_nxt;
  logic             err_nxt;
  logic [CNTW-1:0]  errcnt_nxt;

  logic pred;
  logic hit;
  logic lockup;

  assign pred   = ~(sr[WIDTH-1] ^ sr[TAP-1]);
  assign hit    = (DIN == pred);
  assign lockup = &sr;

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    seed_nxt  = seed_cnt;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_nxt   = 1'b0;
    if (VALID) begin
      case (state)
        SEED: begin
          sr_nxt = {sr[WIDTH-2:0], DIN};
          if (seed_cnt == SW'(WIDTH - 1)) begin
            seed_nxt  = '0;
            match_nxt = '0;
            state_nxt = CHECK;
          end else begin
            seed_nxt = seed_cnt + 1'b1;
          end
        end
        CHECK: begin
          sr_nxt = {sr[WIDTH-2:0], DIN};
          // A "match" from the all-ones lockup state proves nothing about the seed.
          if (hit && !lockup) begin
            if (match_cnt == MW'(LOCK_N - 1)) begin
              match_nxt = '0;
              miss_nxt  = '0;
              state_nxt = LOCKED;
            end else begin
              match_nxt = match_cnt + 1'b1;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          sr_nxt = {sr[WIDTH-2:0], pred};
          if (hit) begin
            miss_nxt = '0;
          end else begin
            err_nxt = 1'b1;
            if (miss_cnt == UW'(UNLOCK_N - 1)) begin
              miss_nxt  = '0;
              seed_nxt  = '0;
              state_nxt = SEED;
            end else begin
              miss_nxt = miss_cnt + 1'b1;
            end
          end
        end
        default: begin
          seed_nxt  = '0;
          match_nxt = '0;
          miss_nxt  = '0;
          state_nxt = SEED;
        end
      endcase
    end
  end

  always_comb begin
    errcnt_nxt = ERRCNT;
    if (CLR) begin
      errcnt_nxt = err_nxt ? CNTW'(1) : '0;
    end else if (err_nxt && !(&ERRCNT)) begin
      errcnt_nxt = ERRCNT + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state     <= SEED;
      sr        <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      LOCK      <= 1'b0;
      ERR       <= 1'b0;
      ERRCNT    <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      seed_cnt  <= seed_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      LOCK      <= (state_nxt == LOCKED);
      ERR       <= err_nxt;
      ERRCNT    <= errcnt_nxt;
    end
  end

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Directed bench for prbs7_xnor_checker: lock, errors, resync, lockup, gaps, counter, reset.
module tb_prbs7_xnor_checker;

  logic        CLK = 1'b0;
  logic        R;
  logic        DIN;
  logic        VALID;
  logic        CLR;
  logic        LOCK;
  logic        ERR;
  logic [15:0] ERRCNT;
  logic        LOCK4;
  logic        ERR4;
  logic [3:0]  ERRCNT4;

  int tests = 0;
  int fails = 0;
  logic [6:0] gh;

  always #5 CLK = ~CLK;

  prbs7_xnor_checker dut (
    .CLK(CLK), .R(R), .DIN(DIN), .VALID(VALID), .CLR(CLR),
    .LOCK(LOCK), .ERR(ERR), .ERRCNT(ERRCNT)
  );

  prbs7_xnor_checker #(.CNTW(4)) dut4 (
    .CLK(CLK), .R(R), .DIN(DIN), .VALID(VALID), .CLR(CLR),
    .LOCK(LOCK4), .ERR(ERR4), .ERRCNT(ERRCNT4)
  );

  // Reference generator: b(n) = ~(b(n-7) ^ b(n-6)), history gh[0] = newest bit.
  task automatic beat(input logic valid, input logic flip);
    logic b;
    b = ~(gh[6] ^ gh[5]);
    VALID = valid;
    DIN = valid ? (b ^ flip) : 1'($urandom_range(0, 1));
    @(posedge CLK);
    #1;
    if (valid) gh = {gh[5:0], b};
    VALID = 1'b0;
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    VALID = 1'b0;
    DIN = 1'b0;
    R = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    R = 1'b1;
    gh = '0;
  endtask

  task automatic test_reset();
    R = 1'b1; CLR = 1'b0; VALID = 1'b0; DIN = 1'b0;
    #2;
    R = 1'b0;
    #1;
    tests++; if (LOCK !== 1'b0) begin fails++; $display("FAIL reset_lock: got %b want 0", LOCK); end
    tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", ERR); end
    tests++; if (ERRCNT !== 16'd0) begin fails++; $display("FAIL reset_errcnt: got %0d want 0", ERRCNT); end
    tests++; if (ERRCNT4 !== 4'd0) begin fails++; $display("FAIL reset_errcnt4: got %0d want 0", ERRCNT4); end
    repeat (2) @(posedge CLK);
    #2;
    R = 1'b1;
  endtask

  task automatic test_clean_lock();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      beat(1'b1, 1'b0);
      if (ERR) errs++;
      if (i == 22) begin
        tests++; if (LOCK !== 1'b0) begin fails++; $display("FAIL clean_prelock22: got %b want 0", LOCK); end
      end
      if (i == 23) begin
        tests++; if (LOCK !== 1'b1) begin fails++; $display("FAIL clean_lock23: got %b want 1", LOCK); end
      end
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL clean_err_pulses: got %0d want 0", errs); end
    tests++; if (ERRCNT !== 16'd0) begin fails++; $display("FAIL clean_errcnt: got %0d want 0", ERRCNT); end
    tests++; if (LOCK !== 1'b1) begin fails++; $display("FAIL clean_lock_end: got %b want 1", LOCK); end
  endtask

  task automatic test_single_error();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 1; i <= 400; i++) begin
      beat(1'b1, (i == 200));
      if (ERR) pulses++;
      if (i == 199) begin
        tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL single_err_before: got %b want 0", ERR); end
      end
      if (i == 200) begin
        tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL single_err_pulse: got %b want 1", ERR); end
        tests++; if (ERRCNT !== 16'd1) begin fails++; $display("FAIL single_errcnt_edge: got %0d want 1", ERRCNT); end
        tests++; if (LOCK !== 1'b1) begin fails++; $display("FAIL single_lock_held: got %b want 1", LOCK); end
      end
      if (i == 201) begin
        tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL single_err_after: got %b want 0", ERR); end
      end
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL single_pulse_count: got %0d want 1", pulses); end
    tests++; if (ERRCNT !== 16'd1) begin fails++; $display("FAIL single_errcnt_end: got %0d want 1", ERRCNT); end
    tests++; if (LOCK !== 1'b1) begin fails++; $display("FAIL single_lock_end: got %b want 1", LOCK); end
  endtask

  // Runs from the locked state left by test_single_error (ERRCNT = 1).
  task automatic test_loss_of_lock();
    int n;
    logic exp_lock;
    for (int k = 1; k <= 4; k++) begin
      beat(1'b1, 1'b1);
      exp_lock = (k < 4);
      tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL loss_err_b2b%0d: got %b want 1", k, ERR); end
      tests++; if (ERRCNT !== 16'(1 + k)) begin fails++; $display("FAIL loss_errcnt%0d: got %0d want %0d", k, ERRCNT, 1 + k); end
      tests++; if (LOCK !== exp_lock) begin fails++; $display("FAIL loss_lock%0d: got %b want %b", k, LOCK, exp_lock); end
    end
    n = 0;
    while (!LOCK && n < 100) begin
      beat(1'b1, 1'b0);
      n++;
    end
    tests++; if (n != 23) begin fails++; $display("FAIL loss_relock_beats: got %0d want 23", n); end
    tests++; if (ERRCNT !== 16'd5) begin fails++; $display("FAIL loss_errcnt_end: got %0d want 5", ERRCNT); end
  endtask

  task automatic test_lockup();
    int seen_lock, seen_err;
    seen_lock = 0;
    seen_err = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      VALID = 1'b1;
      DIN = 1'b1;
      @(posedge CLK);
      #1;
      if (LOCK) seen_lock++;
      if (ERR) seen_err++;
    end
    VALID = 1'b0;
    tests++; if (seen_lock != 0) begin fails++; $display("FAIL lockup_lock: got %0d locked cycles want 0", seen_lock); end
    tests++; if (seen_err != 0) begin fails++; $display("FAIL lockup_err: got %0d pulses want 0", seen_err); end
    tests++; if (ERRCNT !== 16'd0) begin fails++; $display("FAIL lockup_errcnt: got %0d want 0", ERRCNT); end
  endtask

  task automatic test_gaps();
    int beats, errs, gap_errs, cyc;
    logic v;
    beats = 0; errs = 0; gap_errs = 0; cyc = 0;
    do_reset();
    while (beats < 1000 && cyc < 4000) begin
      v = ($urandom_range(0, 99) >= 30);
      beat(v, 1'b0);
      cyc++;
      if (ERR) errs++;
      if (!v && ERR) gap_errs++;
      if (v) begin
        beats++;
        if (beats == 22) begin
          tests++; if (LOCK !== 1'b0) begin fails++; $display("FAIL gaps_prelock22: got %b want 0", LOCK); end
        end
        if (beats == 23) begin
          tests++; if (LOCK !== 1'b1) begin fails++; $display("FAIL gaps_lock23: got %b want 1", LOCK); end
        end
      end
    end
    tests++; if (beats != 1000) begin fails++; $display("FAIL gaps_budget: got %0d beats want 1000", beats); end
    tests++; if (errs != 0) begin fails++; $display("FAIL gaps_err: got %0d pulses want 0", errs); end
    tests++; if (gap_errs != 0) begin fails++; $display("FAIL gaps_err_after_gap: got %0d want 0", gap_errs); end
    tests++; if (ERRCNT !== 16'd0) begin fails++; $display("FAIL gaps_errcnt: got %0d want 0", ERRCNT); end
  endtask

  task automatic test_counter();
    int exp4;
    do_reset();
    repeat (30) beat(1'b1, 1'b0);
    tests++; if (LOCK4 !== 1'b1) begin fails++; $display("FAIL cnt_locked: got %b want 1", LOCK4); end
    for (int k = 1; k <= 20; k++) begin
      beat(1'b1, 1'b1);
      exp4 = (k > 15) ? 15 : k;
      tests++; if (ERRCNT4 !== 4'(exp4)) begin fails++; $display("FAIL cnt_sat%0d: got %0d want %0d", k, ERRCNT4, exp4); end
      tests++; if (ERRCNT !== 16'(k)) begin fails++; $display("FAIL cnt_wide%0d: got %0d want %0d", k, ERRCNT, k); end
      repeat (9) beat(1'b1, 1'b0);
    end
    tests++; if (LOCK4 !== 1'b1) begin fails++; $display("FAIL cnt_lock_kept: got %b want 1", LOCK4); end
    CLR = 1'b1;
    beat(1'b1, 1'b0);
    CLR = 1'b0;
    tests++; if (ERRCNT4 !== 4'd0) begin fails++; $display("FAIL cnt_clr: got %0d want 0", ERRCNT4); end
    tests++; if (ERRCNT !== 16'd0) begin fails++; $display("FAIL cnt_clr_wide: got %0d want 0", ERRCNT); end
    repeat (3) beat(1'b1, 1'b0);
    CLR = 1'b1;
    beat(1'b1, 1'b1);
    CLR = 1'b0;
    tests++; if (ERRCNT4 !== 4'd1) begin fails++; $display("FAIL cnt_clr_err: got %0d want 1", ERRCNT4); end
    tests++; if (ERR4 !== 1'b1) begin fails++; $display("FAIL cnt_clr_err_pulse: got %b want 1", ERR4); end
    repeat (3) beat(1'b1, 1'b0);
    CLR = 1'b1;
    beat(1'b0, 1'b0);
    CLR = 1'b0;
    tests++; if (ERRCNT4 !== 4'd0) begin fails++; $display("FAIL cnt_clr_novalid: got %0d want 0", ERRCNT4); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    repeat (30) beat(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat(1'b1, 1'b1);
      repeat (4) beat(1'b1, 1'b0);
    end
    beat(1'b1, 1'b1);
    tests++; if (ERRCNT !== 16'd5) begin fails++; $display("FAIL mid_pre_errcnt: got %0d want 5", ERRCNT); end
    tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL mid_pre_err: got %b want 1", ERR); end
    #2;
    R = 1'b0;
    #1;
    tests++; if (LOCK !== 1'b0) begin fails++; $display("FAIL mid_async_lock: got %b want 0", LOCK); end
    tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL mid_async_err: got %b want 0", ERR); end
    tests++; if (ERRCNT !== 16'd0) begin fails++; $display("FAIL mid_async_errcnt: got %0d want 0", ERRCNT); end
    #3;
    R = 1'b1;
    gh = '0;
    n = 0;
    while (!LOCK && n < 100) begin
      beat(1'b1, 1'b0);
      n++;
    end
    tests++; if (n != 23) begin fails++; $display("FAIL mid_relock_beats: got %0d want 23", n); end
  endtask

  initial begin
    gh = '0;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_lockup();
    test_gaps();
    test_counter();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prbs7_xnor_checker.md
# prbs7_xnor_checker

Serial PRBS checker for the receive end of the team's XNOR-feedback pseudo-random bit stream, the counterpart of the XNOR-LFSR pattern generator used for link and scan bring-up on the tsmc018 flow. It self-synchronises to an incoming one-bit-per-beat stream, declares lock, then free-runs a local reference LFSR and flags every mismatching bit. It counts the mismatches and drops lock on sustained loss.

## Interface
Parameters:
- WIDTH, 7: LFSR length. Polynomial x^WIDTH + x^TAP + 1.
- TAP, 6: second feedback tap.
- LOCK_N, 16: consecutive matching beats needed to declare lock.
- UNLOCK_N, 4: consecutive mismatching beats while locked that force resync.
- CNTW, 16: width of the error counter.

Ports:
- CLK  in  1  single clock. All logic is rising-edge.
- R  in  1  asynchronous, active-low reset.
- DIN  in  1  received data bit.
- VALID  in  1  DIN is a valid beat this cycle.
- CLR  in  1  synchronous clear of ERRCNT.
- LOCK  out  1  checker is locked to the stream.
- ERR  out  1  one-cycle pulse per mismatching beat while locked.
- ERRCNT  out  CNTW  saturating count of mismatches.

## Operation
- Shift register `sr[WIDTH-1:0]`. On a shift, the new bit enters `sr[0]` and contents move toward the MSB.
- Predicted bit: `p = ~(sr[WIDTH-1] ^ sr[TAP-1])` (XNOR feedback).
- Only cycles with VALID=1 ("beats") advance any state. With VALID=0, everything holds and ERR=0.
- FSM states:
  - SEED
    - Shift DIN into sr.
    - Seed counter counts beats 0..WIDTH-1.
    - On the WIDTH-th beat, go to CHECK with the match count cleared.
  - CHECK
    - Compare DIN with p, then shift DIN into sr.
    - A match increments the match count. A mismatch clears it. ERR is never asserted in this state.
    - A match while sr is all-ones does not count and clears the match count, because all-ones is the XNOR lockup state.
    - On the LOCK_N-th consecutive counted match, go to LOCKED.
  - LOCKED
    - Shift p (not DIN) into sr.
    - On a mismatch, pulse ERR, increment ERRCNT, and increment the miss count.
    - A match clears the miss count.
    - On the UNLOCK_N-th consecutive mismatch, go to SEED with the seed counter cleared.
- ERRCNT:
  - Saturates at 2^CNTW-1 and never wraps.
  - CLR=1 with no error that cycle sets it to 0.
  - CLR=1 coinciding with a locked mismatch sets it to 1.
  - CLR is honoured regardless of VALID.
- Reset (R=0), asynchronous and at any time, including mid-lock:
  - sr = 0, state = SEED, all internal counters = 0.
  - LOCK = 0, ERR = 0, ERRCNT = 0.

## Timing
- All outputs are registered and change only on a CLK rising edge, except for the asynchronous reset.
- ERR latency: high for exactly the one cycle following the mismatching beat.
- ERRCNT latency: updates on the same edge that ERR rises.
- LOCK rises on the edge that consumes the LOCK_N-th matching beat.
  - From reset with an error-free stream and continuous VALID, LOCK is 1 after WIDTH+LOCK_N beats (23 with defaults).
- LOCK falls on the edge that consumes the UNLOCK_N-th consecutive mismatch. ERR pulses for that beat as well.
- Back-to-back mismatches produce ERR held high continuously, one count per beat.
- Throughput is one bit per clock, with no stall cycles.

## Test plan
1. **Clean lock.**
   - Stimulus: reset, then continuous VALID with a generator stream started from all-zeros seed.
   - Required: LOCK=1 after 23 beats. ERRCNT=0 and ERR never asserted over 1000 beats.
2. **Single error.**
   - Stimulus: while locked, invert beat 200.
   - Required: exactly one ERR pulse, the cycle after beat 200. ERRCNT=1. LOCK stays 1. Subsequent beats are clean.
3. **Loss of lock.**
   - Stimulus: while locked, invert 4 consecutive beats.
   - Required: ERRCNT increments 4 times and LOCK falls after the 4th. With the clean stream resumed, LOCK returns after 23 more beats.
4. **Lockup pattern and gaps.**
   - Stimulus A: constant DIN=1 for 1000 beats. Required: LOCK stays 0 and ERR=0.
   - Stimulus B: rerun scenario 1 with VALID randomly deasserted 30% of cycles. Required: the same beat-count results, and ERR never rises after a non-beat cycle.
5. **Counter rules.**
   - Stimulus: CNTW=4, 20 isolated errors while locked.
   - Required: ERRCNT saturates at 15. CLR alone gives 0. CLR on the same beat as an error gives 1.
6. **Reset mid-operation.**
   - Stimulus: assert R=0 asynchronously between clock edges while locked with ERRCNT=5.
   - Required: LOCK, ERR and ERRCNT are 0 immediately, without waiting for an edge. After release, relock takes 23 beats.
